// File: rtl/cpu_core8_if.sv
// rtl/cpu_core8_if.sv - host load/debug bus between a host and cpu_core8
interface cpu_core8_if;
    logic       isReg;
    logic [7:0] i_inst;
    logic [7:0] i_cpu_addr;
    logic [7:0] o_CPU_data;
    logic       o_is_done;

    modport master (
        output isReg,
        output i_inst,
        output i_cpu_addr,
        input  o_CPU_data,
        input  o_is_done
    );

    modport slave (
        input  isReg,
        input  i_inst,
        input  i_cpu_addr,
        output o_CPU_data,
        output o_is_done
    );
endinterface

// File: rtl/cpu_core8.sv
// rtl/cpu_core8.sv - 8-bit single-cycle CPU with host-loaded program store and debug readback
module cpu_core8 (
    input  logic         clk,
    input  logic         rst,
    cpu_core8_if.slave   bus
);
    typedef enum logic [1:0] {S_LOAD, S_RUN, S_DONE} state_t;

    state_t     state;
    logic [7:0] pc;
    logic       is_done;

    logic [7:0] im [256];
    logic [7:0] rf [8];
    logic [7:0] dm [256];

    logic [15:0] instr;
    logic [3:0]  op;
    logic [2:0]  rd, rs, rt, sh;
    logic [7:0]  rd_val, rs_val, rt_val;
    logic [7:0]  imm6_sext, imm8, eff_addr;
    logic [7:0]  pc_plus2, pc_next;
    logic [7:0]  wb_data;
    logic        rf_we;
    logic [7:0]  prev_addr;

    assign instr     = {im[pc], im[pc + 8'd1]};
    assign op        = instr[15:12];
    assign rd        = instr[11:9];
    assign rs        = instr[8:6];
    assign rt        = instr[5:3];
    assign sh        = instr[2:0];
    assign imm8      = instr[7:0];
    assign imm6_sext = {{2{instr[5]}}, instr[5:0]};
    assign rd_val    = rf[rd];
    assign rs_val    = rf[rs];
    assign rt_val    = rf[rt];
    assign eff_addr  = rs_val + imm6_sext;
    assign pc_plus2  = pc + 8'd2;
    assign prev_addr = bus.i_cpu_addr - 8'd1;

    // Decode: register writeback value/enable and next PC for the current instruction
    always_comb begin
        wb_data = 8'd0;
        rf_we   = 1'b0;
        pc_next = pc_plus2;
        case (op)
            4'h1: begin wb_data = rs_val + rt_val;  rf_we = 1'b1; end
            4'h2: begin wb_data = rs_val - rt_val;  rf_we = 1'b1; end
            4'h3: begin wb_data = rs_val & rt_val;  rf_we = 1'b1; end
            4'h4: begin wb_data = rs_val | rt_val;  rf_we = 1'b1; end
            4'h5: begin wb_data = rs_val ^ rt_val;  rf_we = 1'b1; end
            4'h6: begin wb_data = rs_val << sh;     rf_we = 1'b1; end
            4'h7: begin wb_data = rs_val >> sh;     rf_we = 1'b1; end
            4'h8: begin wb_data = imm8;             rf_we = 1'b1; end
            4'h9: begin wb_data = eff_addr;         rf_we = 1'b1; end
            4'hA: begin wb_data = dm[eff_addr];     rf_we = 1'b1; end
            4'hC: if (rd_val == rs_val) pc_next = pc_plus2 + {imm6_sext[6:0], 1'b0};
            4'hD: if (rd_val != rs_val) pc_next = pc_plus2 + {imm6_sext[6:0], 1'b0};
            4'hE: pc_next = {imm8[7:1], 1'b0};
            default: ;
        endcase
    end

    // Control FSM: LOAD until a HLT instruction is fully stored, RUN to HLT, then park in DONE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_LOAD;
            pc      <= 8'd0;
            is_done <= 1'b0;
        end else begin
            case (state)
                S_LOAD: begin
                    if (bus.i_cpu_addr[0] && (im[prev_addr][7:4] == 4'hF)) begin
                        state <= S_RUN;
                        pc    <= 8'd0;
                    end
                end
                S_RUN: begin
                    if (op == 4'hF) begin
                        state   <= S_DONE;
                        is_done <= 1'b1;
                    end else begin
                        pc <= pc_next;
                    end
                end
                default: ;
            endcase
        end
    end

    // Program store: written only while loading, survives reset
    always_ff @(posedge clk) begin
        if (rst && state == S_LOAD)
            im[bus.i_cpu_addr] <= bus.i_inst;
    end

    // Register file writeback
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 8; i++) rf[i] <= 8'd0;
        end else if (state == S_RUN && rf_we) begin
            rf[rd] <= wb_data;
        end
    end

    // Data memory store path
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 256; i++) dm[i] <= 8'd0;
        end else if (state == S_RUN && op == 4'hB) begin
            dm[eff_addr] <= rd_val;
        end
    end

    assign bus.o_CPU_data = bus.isReg ? rf[bus.i_cpu_addr[2:0]] : dm[bus.i_cpu_addr];
    assign bus.o_is_done  = is_done;
endmodule

// File: tb/tb_cpu_core8.sv
// tb/tb_cpu_core8.sv - directed self-checking bench for cpu_core8
module tb_cpu_core8;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;

    logic [15:0] prog [0:15];
    int          prog_len;

    cpu_core8_if bus ();

    cpu_core8 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
    endtask

    task automatic rd_reg(input logic [2:0] idx, output logic [7:0] val);
        bus.isReg = 1'b1;
        bus.i_cpu_addr = {5'd0, idx};
        #1 val = bus.o_CPU_data;
    endtask

    task automatic rd_dm(input logic [7:0] addr, output logic [7:0] val);
        bus.isReg = 1'b0;
        bus.i_cpu_addr = addr;
        #1 val = bus.o_CPU_data;
    endtask

    task automatic chk_reg(input string tag, input logic [2:0] idx, input logic [7:0] exp);
        logic [7:0] v;
        rd_reg(idx, v);
        check(tag, v, exp);
    endtask

    task automatic chk_dm(input string tag, input logic [7:0] addr, input logic [7:0] exp);
        logic [7:0] v;
        rd_dm(addr, v);
        check(tag, v, exp);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        bus.i_cpu_addr = 8'd0;
        bus.i_inst = 8'd0;
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        bus.i_cpu_addr = 8'd0;
        bus.i_inst = 8'd0;
        rst = 1'b1;
    endtask

    task automatic load_prog();
        for (int i = 0; i < prog_len; i++) begin
            @(negedge clk);
            bus.i_cpu_addr = 8'(2 * i);
            bus.i_inst = prog[i][15:8];
            @(negedge clk);
            bus.i_cpu_addr = 8'(2 * i + 1);
            bus.i_inst = prog[i][7:0];
        end
    endtask

    task automatic wait_done(input string tag, input int budget);
        int cyc = 0;
        while (bus.o_is_done !== 1'b1 && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        check(tag, {7'd0, bus.o_is_done}, 8'd1);
    endtask

    initial begin
        bus.isReg = 1'b1;
        bus.i_inst = 8'd0;
        bus.i_cpu_addr = 8'd0;

        // 1 reset state
        apply_reset();
        check("rst_done", {7'd0, bus.o_is_done}, 8'd0);
        for (int i = 0; i < 8; i++) chk_reg($sformatf("rst_r%0d", i), 3'(i), 8'd0);
        for (int i = 0; i < 10; i++) chk_dm($sformatf("rst_dm%0d", i), 8'(i), 8'd0);
        release_reset();

        // 2 ALU
        prog[0] = 16'h8205; prog[1] = 16'h8403; prog[2] = 16'h1650; prog[3] = 16'hF000;
        prog_len = 4;
        load_prog();
        wait_done("alu_done", 50);
        chk_reg("alu_r3", 3, 8'd8);
        chk_reg("alu_r1", 1, 8'd5);
        chk_reg("alu_r2", 2, 8'd3);

        // 3 memory
        apply_reset();
        release_reset();
        prog[0] = 16'h822A; prog[1] = 16'hB204; prog[2] = 16'hA404; prog[3] = 16'hF000;
        prog_len = 4;
        load_prog();
        wait_done("mem_done", 50);
        chk_dm("mem_dm4", 4, 8'd42);
        chk_reg("mem_r2", 2, 8'd42);
        chk_dm("mem_dm3", 3, 8'd0);
        chk_dm("mem_dm5", 5, 8'd0);

        // 4 loop with backward branch, r1 counts 3 -> 256 wraps to 0
        apply_reset();
        release_reset();
        prog[0] = 16'h8203; prog[1] = 16'h9241; prog[2] = 16'hD23E; prog[3] = 16'hF000;
        prog_len = 4;
        load_prog();
        wait_done("loop_done", 1000);
        chk_reg("loop_r1", 1, 8'd0);

        // 5 modulo-256 wrap
        apply_reset();
        release_reset();
        prog[0] = 16'h82C8; prog[1] = 16'h8464; prog[2] = 16'h1650; prog[3] = 16'h2888;
        prog[4] = 16'hF000;
        prog_len = 5;
        load_prog();
        wait_done("wrap_done", 50);
        chk_reg("wrap_r3", 3, 8'd44);
        chk_reg("wrap_r4", 4, 8'd156);

        // logic ops, shifts, JMP and taken BEQ skipping writes to r0
        apply_reset();
        release_reset();
        prog[0]  = 16'h8296; prog[1]  = 16'h843C; prog[2]  = 16'h3650; prog[3]  = 16'h4850;
        prog[4]  = 16'h5A50; prog[5]  = 16'h6C43; prog[6]  = 16'h7E42; prog[7]  = 16'hE014;
        prog[8]  = 16'h80EE; prog[9]  = 16'h0000; prog[10] = 16'hC001; prog[11] = 16'h8077;
        prog[12] = 16'hF000;
        prog_len = 13;
        load_prog();
        wait_done("ops_done", 50);
        chk_reg("ops_and", 3, 8'h14);
        chk_reg("ops_or",  4, 8'hBE);
        chk_reg("ops_xor", 5, 8'hAA);
        chk_reg("ops_sll", 6, 8'hB0);
        chk_reg("ops_srl", 7, 8'h25);
        chk_reg("ops_r0",  0, 8'h00);

        // 6 abort mid-run, then reload and rerun
        apply_reset();
        release_reset();
        prog[0] = 16'h8203; prog[1] = 16'h9241; prog[2] = 16'hD23E; prog[3] = 16'hF000;
        prog_len = 4;
        load_prog();
        repeat (40) @(negedge clk);
        check("abort_running", {7'd0, bus.o_is_done}, 8'd0);
        apply_reset();
        check("abort_done", {7'd0, bus.o_is_done}, 8'd0);
        chk_reg("abort_r1", 1, 8'd0);
        chk_dm("abort_dm0", 0, 8'd0);
        release_reset();
        prog[0] = 16'h82C8; prog[1] = 16'h8464; prog[2] = 16'h1650; prog[3] = 16'h2888;
        prog[4] = 16'hF000;
        prog_len = 5;
        load_prog();
        wait_done("rerun_done", 50);
        chk_reg("rerun_r3", 3, 8'd44);
        chk_reg("rerun_r4", 4, 8'd156);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
